// File: rtl/ex_mem_pipe_pkg.sv
// Shared constants and stall-state encoding for the EX/MEM pipeline register.
package ex_mem_pipe_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int RADDR_W_DEF = 5;
    localparam int OP_W_DEF    = 8;
    localparam int CNT_W_DEF   = 2;

    localparam logic                   RstEnable    = 1'b1;
    localparam logic                   WriteDisable = 1'b0;
    localparam logic [DATA_W_DEF-1:0]  ZeroWord     = '0;
    localparam logic [RADDR_W_DEF-1:0] NOPRegAddr   = '0;
    localparam logic [OP_W_DEF-1:0]    EXE_NOP_OP   = '0;

    typedef enum logic [1:0] {
        ADVANCE = 2'd0,
        BUBBLE  = 2'd1,
        HOLD    = 2'd2,
        FLUSH   = 2'd3
    } stall_st_t;

endpackage

// File: rtl/ex_mem_pipe_ctl_decode.sv
// Combinational priority decode of reset/flush/stall into one pipeline action.
module ex_mem_pipe_ctl_decode
    import ex_mem_pipe_pkg::*;
(
    input  logic      rst,
    input  logic      flush,
    input  logic      stall_ex,
    input  logic      stall_mem,
    output stall_st_t st
);

    // stall_mem without stall_ex cannot come from ctrl; folding it into HOLD keeps state safe.
    always_comb begin
        st = ADVANCE;
        if (rst == RstEnable || flush)
            st = FLUSH;
        else if (stall_mem)
            st = HOLD;
        else if (stall_ex)
            st = BUBBLE;
    end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with flush/hold/bubble control and multi-cycle feedback to EX.
// One cycle ex_* to mem_*; bubbles carry no architectural writes.
module ex_mem_pipe
    import ex_mem_pipe_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RADDR_W = RADDR_W_DEF,
    parameter int OP_W    = OP_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_ex,
    input  logic                stall_mem,
    input  logic                flush,
    input  logic [RADDR_W-1:0]  ex_waddr,
    input  logic                ex_we,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic                ex_whilo,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic [OP_W-1:0]     ex_aluop,
    input  logic [DATA_W-1:0]   ex_mem_addr,
    input  logic [DATA_W-1:0]   ex_mem_sdata,
    input  logic [2*DATA_W-1:0] ex_hilo_temp,
    input  logic [CNT_W-1:0]    ex_cnt,
    output logic [RADDR_W-1:0]  mem_waddr,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_whilo,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic [OP_W-1:0]     mem_aluop,
    output logic [DATA_W-1:0]   mem_mem_addr,
    output logic [DATA_W-1:0]   mem_mem_sdata,
    output logic                mem_valid,
    output logic [2*DATA_W-1:0] hilo_temp_fb,
    output logic [CNT_W-1:0]    cnt_fb
);

    stall_st_t st;

    ex_mem_pipe_ctl_decode u_decode (
        .rst       (rst),
        .flush     (flush),
        .stall_ex  (stall_ex),
        .stall_mem (stall_mem),
        .st        (st)
    );

    always_ff @(posedge clk) begin
        case (st)
            FLUSH: begin
                mem_waddr     <= RADDR_W'(NOPRegAddr);
                mem_we        <= WriteDisable;
                mem_wdata     <= DATA_W'(ZeroWord);
                mem_whilo     <= WriteDisable;
                mem_hi        <= DATA_W'(ZeroWord);
                mem_lo        <= DATA_W'(ZeroWord);
                mem_aluop     <= OP_W'(EXE_NOP_OP);
                mem_mem_addr  <= DATA_W'(ZeroWord);
                mem_mem_sdata <= DATA_W'(ZeroWord);
                mem_valid     <= 1'b0;
                hilo_temp_fb  <= '0;
                cnt_fb        <= '0;
            end
            // MEM sees a NOP while EX's partial accumulate is parked in the feedback regs.
            BUBBLE: begin
                mem_waddr     <= RADDR_W'(NOPRegAddr);
                mem_we        <= WriteDisable;
                mem_wdata     <= DATA_W'(ZeroWord);
                mem_whilo     <= WriteDisable;
                mem_hi        <= DATA_W'(ZeroWord);
                mem_lo        <= DATA_W'(ZeroWord);
                mem_aluop     <= OP_W'(EXE_NOP_OP);
                mem_mem_addr  <= DATA_W'(ZeroWord);
                mem_mem_sdata <= DATA_W'(ZeroWord);
                mem_valid     <= 1'b0;
                hilo_temp_fb  <= ex_hilo_temp;
                cnt_fb        <= ex_cnt;
            end
            ADVANCE: begin
                mem_waddr     <= ex_waddr;
                mem_we        <= ex_we;
                mem_wdata     <= ex_wdata;
                mem_whilo     <= ex_whilo;
                mem_hi        <= ex_hi;
                mem_lo        <= ex_lo;
                mem_aluop     <= ex_aluop;
                mem_mem_addr  <= ex_mem_addr;
                mem_mem_sdata <= ex_mem_sdata;
                mem_valid     <= 1'b1;
                hilo_temp_fb  <= '0;
                cnt_fb        <= '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Scoreboard bench for ex_mem_pipe: driver queues expected outputs, monitor checks after each edge.
module tb_ex_mem_pipe;

    typedef struct packed {
        logic [4:0]  waddr;
        logic        we;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [7:0]  aluop;
        logic [31:0] maddr;
        logic [31:0] sdata;
        logic [63:0] hilo_temp;
        logic [1:0]  cnt;
    } in_t;

    typedef struct packed {
        logic [4:0]  waddr;
        logic        we;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [7:0]  aluop;
        logic [31:0] maddr;
        logic [31:0] sdata;
        logic        valid;
        logic [63:0] hilo_fb;
        logic [1:0]  cnt_fb;
    } out_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall_ex = 1'b0, stall_mem = 1'b0, flush = 1'b0;
    in_t  ex = '1;
    out_t act;

    logic [4:0]  mem_waddr;
    logic        mem_we, mem_whilo, mem_valid;
    logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_mem_sdata;
    logic [7:0]  mem_aluop;
    logic [63:0] hilo_temp_fb;
    logic [1:0]  cnt_fb;

    int total = 0;
    int bad   = 0;
    out_t exp_q[$];
    string name_q[$];

    always #5 clk = ~clk;

    ex_mem_pipe dut (
        .clk(clk), .rst(rst), .stall_ex(stall_ex), .stall_mem(stall_mem), .flush(flush),
        .ex_waddr(ex.waddr), .ex_we(ex.we), .ex_wdata(ex.wdata), .ex_whilo(ex.whilo),
        .ex_hi(ex.hi), .ex_lo(ex.lo), .ex_aluop(ex.aluop), .ex_mem_addr(ex.maddr),
        .ex_mem_sdata(ex.sdata), .ex_hilo_temp(ex.hilo_temp), .ex_cnt(ex.cnt),
        .mem_waddr(mem_waddr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr),
        .mem_mem_sdata(mem_mem_sdata), .mem_valid(mem_valid), .hilo_temp_fb(hilo_temp_fb),
        .cnt_fb(cnt_fb)
    );

    assign act = '{mem_waddr, mem_we, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_aluop,
                   mem_mem_addr, mem_mem_sdata, mem_valid, hilo_temp_fb, cnt_fb};

    // Expected outputs of a plain advance: fields copied, feedback cleared.
    function automatic out_t adv(input in_t v);
        return '{v.waddr, v.we, v.wdata, v.whilo, v.hi, v.lo, v.aluop,
                 v.maddr, v.sdata, 1'b1, 64'h0, 2'd0};
    endfunction

    function automatic out_t bub(input logic [63:0] ht, input logic [1:0] c);
        out_t o;
        o = '0;
        o.hilo_fb = ht;
        o.cnt_fb  = c;
        return o;
    endfunction

    task automatic drive(input string nm, input logic r, input logic f,
                         input logic se, input logic sm, input in_t v, input out_t e);
        @(negedge clk);
        rst = r; flush = f; stall_ex = se; stall_mem = sm; ex = v;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: one comparison per captured edge with a pending expectation.
    initial begin
        out_t e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (rst === 1'b0 && stall_ex === 1'b0 && stall_mem === 1'b1) begin
                bad++;
                $display("FAIL illegal_stall: stall_mem=1 with stall_ex=0 required never");
            end
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                total++;
                if (act !== e) begin
                    bad++;
                    $display("FAIL %s: got %h want %h", nm, act, e);
                end
            end
        end
    end

    initial begin
        in_t a, b, c, d, v;
        out_t zero;
        zero = '0;

        ex = '1;
        drive("reset0", 1, 0, 0, 0, ex, zero);
        drive("reset1", 1, 0, 0, 0, ex, zero);
        drive("reset_release", 0, 0, 0, 0, ex, adv(ex));

        a = '0; a.waddr = 5'd5; a.we = 1'b1; a.wdata = 32'h1234_5678;
        a.aluop = 8'h23; a.maddr = 32'h100;
        drive("advance", 0, 0, 0, 0, a, '{5'd5, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 32'h0,
                                          8'h23, 32'h100, 32'h0, 1'b1, 64'h0, 2'd0});

        b = a; b.hilo_temp = 64'h0000_0001_8000_0000; b.cnt = 2'd1;
        drive("bubble_madd", 0, 0, 1, 0, b, bub(64'h0000_0001_8000_0000, 2'd1));
        b.cnt = 2'd2; b.hilo_temp = 64'hDEAD_BEEF_0000_0001; b.wdata = 32'h0BAD_F00D;
        drive("after_bubble", 0, 0, 0, 0, b, adv(b));

        c = '0; c.waddr = 5'd9; c.we = 1'b1; c.wdata = 32'hAA; c.cnt = 2'd3;
        drive("load_aa", 0, 0, 0, 0, c, adv(c));
        for (int i = 0; i < 3; i++) begin
            v = c; v.wdata = 32'h100 + i; v.cnt = 2'(i);
            drive("hold", 0, 0, 1, 1, v, adv(c));
        end

        d = c; d.hilo_temp = 64'h1111_2222_3333_4444; d.cnt = 2'd1;
        drive("bubble_pre_hold", 0, 0, 1, 0, d, bub(64'h1111_2222_3333_4444, 2'd1));
        d.hilo_temp = 64'h5; d.cnt = 2'd3;
        drive("hold_keeps_fb", 0, 0, 1, 1, d, bub(64'h1111_2222_3333_4444, 2'd1));

        drive("reload", 0, 0, 0, 0, a, adv(a));
        drive("flush_over_hold", 0, 1, 1, 1, c, zero);
        drive("reload2", 0, 0, 0, 0, c, adv(c));
        drive("flush_with_rst", 1, 1, 0, 0, c, zero);
        drive("reload3", 0, 0, 0, 0, a, adv(a));
        drive("flush_over_bubble", 0, 1, 1, 0, d, zero);

        for (int i = 0; i < 8; i++) begin
            v.waddr = 5'(i + 1); v.we = 1'b1; v.wdata = 32'hA000_0000 + i;
            v.whilo = i[0]; v.hi = 32'h11 * i; v.lo = ~32'(i); v.aluop = 8'h20 + 8'(i);
            v.maddr = 32'h1000 + 32'(4 * i); v.sdata = 32'h5500 + i;
            v.hilo_temp = 64'hFFFF_0000_0000_0000 | 64'(i); v.cnt = 2'(i);
            drive("b2b", 0, 0, 0, 0, v, adv(v));
        end

        for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: pending=%0d required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
